// File: rtl/inv_key_schedule.sv
// AES-128 key schedule that emits the round keys in descending order (10 down to 0).
// A cipher key is first expanded forward to round 10; a round-10 key is used directly.
module inv_key_schedule #(
    parameter int KEY_WIDTH = 128          // only 128 (AES-128, Nr = 10) is supported
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_is_last,
    input  logic [KEY_WIDTH-1:0] in_key,
    input  logic                 key_ready,
    output logic                 key_valid,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic [3:0]           round_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_REV  = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t         r_state;
    state_t         w_state_next;
    logic [127:0]   r_key;
    logic [127:0]   w_key_next;
    logic [3:0]     r_rnd;
    logic [3:0]     w_rnd_next;
    logic           r_done;
    logic           w_done_next;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_p0, w_p1, w_p2, w_p3;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_rot;
    logic [31:0]    w_sub;
    logic [3:0]     w_rcon_idx;
    logic [7:0]     w_rcon;
    logic [127:0]   w_fwd_key;
    logic [127:0]   w_inv_key;
    logic           w_handshake;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // One SubWord serves both directions: forward steps substitute w3, reverse steps
    // substitute the recovered previous w3 (w3 ^ w2).
    assign w_p3       = w_w3 ^ w_w2;
    assign w_sub_in   = (r_state == S_REV) ? w_p3 : w_w3;
    assign w_rot      = {w_sub_in[23:0], w_sub_in[31:24]};
    assign w_rcon_idx = (r_state == S_REV) ? r_rnd : (r_rnd + 4'd1);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[gi*8 +: 8] = SBOX[w_rot[gi*8 +: 8]];
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        case (w_rcon_idx)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_n0      = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};
    assign w_n1      = w_n0 ^ w_w1;
    assign w_n2      = w_n1 ^ w_w2;
    assign w_n3      = w_n2 ^ w_w3;
    assign w_fwd_key = {w_n0, w_n1, w_n2, w_n3};

    assign w_p2      = w_w2 ^ w_w1;
    assign w_p1      = w_w1 ^ w_w0;
    assign w_p0      = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};
    assign w_inv_key = {w_p0, w_p1, w_p2, w_p3};

    assign w_handshake = key_valid & key_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_rnd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_rnd   <= w_rnd_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_rnd_next   = r_rnd;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_key_next = in_key;
                    if (in_is_last) begin
                        w_rnd_next   = 4'd10;
                        w_state_next = S_REV;
                    end else begin
                        w_rnd_next   = 4'd0;
                        w_state_next = S_FWD;
                    end
                end
            end
            S_FWD: begin
                w_key_next = w_fwd_key;
                w_rnd_next = r_rnd + 4'd1;
                if (r_rnd == 4'd9) begin
                    w_state_next = S_REV;
                end
            end
            S_REV: begin
                if (w_handshake) begin
                    if (r_rnd != 4'd0) begin
                        w_key_next = w_inv_key;
                        w_rnd_next = r_rnd - 4'd1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        key_valid = (r_state == S_REV);
        busy      = (r_state != S_IDLE);
        key_out   = r_key;
        round_out = r_rnd;
        done      = r_done;
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Randomized bench for inv_key_schedule; expected keys come from a forward
// AES-128 expansion whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         in_is_last = 1'b0;
    logic [127:0] in_key = '0;
    logic         key_ready = 1'b0;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] mdl_rk   [11];
    logic [127:0] got_keys [11];

    always #5 clk = ~clk;

    inv_key_schedule #(.KEY_WIDTH(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_is_last (in_is_last),
        .in_key     (in_key),
        .key_ready  (key_ready),
        .key_valid  (key_valid),
        .key_out    (key_out),
        .round_out  (round_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x = a;
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
                t = t ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    task automatic launch(input bit is_last, input logic [127:0] key);
        in_is_last = is_last;
        in_key     = key;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: ready low 3 cycles at round 7
    task automatic run(input bit is_last, input logic [127:0] ckey, input int mode,
                       input bit chain, input bit n_last, input logic [127:0] n_in);
        logic [127:0] exp [11];
        int  lat;
        int  stall;
        bit  hs;
        expand(ckey);
        for (int r = 0; r < 11; r++) exp[r] = mdl_rk[r];
        lat = 0;
        while (!key_valid && lat < 15) begin
            check("fwd_busy", {127'b0, busy}, 128'd1);
            key_ready  = $urandom_range(0, 1);
            start      = ($urandom_range(0, 2) == 0);
            in_is_last = $urandom_range(0, 1);
            in_key     = rand128();
            tick();
            start = 1'b0;
            lat++;
        end
        check("latency", 128'(lat), is_last ? 128'd0 : 128'd10);
        for (int r = 10; r >= 0; r--) begin
            hs = 1'b0;
            stall = 0;
            while (!hs && stall < 20) begin
                check("valid", {127'b0, key_valid}, 128'd1);
                check("key", key_out, exp[r]);
                check("round", {124'b0, round_out}, 128'(r));
                case (mode)
                    0:       key_ready = 1'b1;
                    1:       key_ready = ($urandom_range(0, 2) != 0);
                    default: key_ready = !(r == 7 && stall < 3);
                endcase
                if (r == 0) begin
                    start = chain;
                    if (chain) begin
                        in_is_last = n_last;
                        in_key     = n_in;
                    end
                end else begin
                    start  = ($urandom_range(0, 3) == 0);
                    in_key = rand128();
                end
                hs = key_ready;
                if (hs) got_keys[r] = key_out;
                tick();
                if (!(chain && r == 0)) start = 1'b0;
                stall++;
            end
            if (!hs) check("hs_timeout", 128'd0, 128'd1);
            if (mode == 2 && r == 7) check("stall_len", 128'(stall), 128'd4);
        end
        key_ready = $urandom_range(0, 1);
        check("done_pulse", {127'b0, done}, 128'd1);
        check("done_busy", {127'b0, busy}, 128'd0);
        check("done_valid", {127'b0, key_valid}, 128'd0);
        $display("[TB] run is_last=%0d cipher_key=%h mode=%0d chain=%0d complete", is_last, ckey, mode, chain);
        tick();
        start = 1'b0;
        if (!chain) check("done_low", {127'b0, done}, 128'd0);
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] k2;
        bit           l;
        int           cnt;

        tick();
        check("rst_valid", {127'b0, key_valid}, 128'd0);
        check("rst_key", key_out, 128'd0);
        check("rst_round", {124'b0, round_out}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, done}, 128'd0);
        tick();
        reset = 1'b1;
        key_ready = 1'b1;
        tick();
        check("idle_valid", {127'b0, key_valid}, 128'd0);

        // Known-answer: cipher key, forward expansion first
        launch(1'b0, 128'h000102030405060708090a0b0c0d0e0f);
        run(1'b0, 128'h000102030405060708090a0b0c0d0e0f, 0, 1'b0, 1'b0, '0);
        check("kat1_r10", got_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("kat1_r9",  got_keys[9],  128'h549932d1f08557681093ed9cbe2c974e);
        check("kat1_r1",  got_keys[1],  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("kat1_r0",  got_keys[0],  128'h000102030405060708090a0b0c0d0e0f);

        // Known-answer: round-10 key supplied directly
        launch(1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run(1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, 1'b0, '0);
        check("kat2_r1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("kat2_r0", got_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Backpressure at round 7
        k = rand128();
        launch(1'b0, k);
        run(1'b0, k, 2, 1'b0, 1'b0, '0);

        // Random keys, random direction, random ready
        for (int i = 0; i < 6; i++) begin
            k = rand128();
            l = $urandom_range(0, 1);
            expand(k);
            launch(l, l ? mdl_rk[10] : k);
            run(l, k, 1, 1'b0, 1'b0, '0);
        end

        // Back-to-back: start held through done
        k  = rand128();
        k2 = rand128();
        expand(k2);
        begin
            logic [127:0] k2_last;
            k2_last = mdl_rk[10];
            expand(k);
            launch(1'b1, mdl_rk[10]);
            run(1'b1, k, 0, 1'b1, 1'b1, k2_last);
            run(1'b1, k2, 0, 1'b0, 1'b0, '0);
        end

        // Reset in the middle of emission
        k = rand128();
        launch(1'b0, k);
        key_ready = 1'b1;
        cnt = 0;
        while (!(key_valid && round_out == 4'd5) && cnt < 40) begin
            tick();
            cnt++;
        end
        check("rst_reach5", {127'b0, (key_valid && round_out == 4'd5)}, 128'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", {127'b0, key_valid}, 128'd0);
        check("arst_key", key_out, 128'd0);
        check("arst_round", {124'b0, round_out}, 128'd0);
        check("arst_busy", {127'b0, busy}, 128'd0);
        check("arst_done", {127'b0, done}, 128'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_valid", {127'b0, key_valid}, 128'd0);
        check("post_rst_busy", {127'b0, busy}, 128'd0);
        k = rand128();
        launch(1'b0, k);
        run(1'b0, k, 1, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
